// File: rtl/gift_subcells_sched_pkg.sv
// Shared types and helpers for the GIFT sequential SubCells engine:
// FSM state encoding, step-count derivation and the inverse S-box table.
package gift_subcells_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_e;

    // Inverse GIFT S-box, indexed by the input nibble.
    localparam logic [3:0] SBOX_INV_TABLE [16] = '{
        4'hD, 4'h0, 4'h8, 4'h6, 4'h2, 4'hC, 4'h4, 4'hB,
        4'hE, 4'h7, 4'h1, 4'hA, 4'h3, 4'h9, 4'hF, 4'h5
    };

    function automatic int unsigned calc_steps(input int unsigned state_w,
                                               input int unsigned lanes);
        return state_w / (4 * lanes);
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV_TABLE[x];
    endfunction

endpackage

// File: rtl/gift_subcells_sched_sbox.sv
// GiftSboxFun lane: forward 4-bit GIFT S-box, purely combinational.
module gift_subcells_sched_sbox (
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    always_comb begin
        y_o = 4'hE;
        case (x_i)
            4'h0: y_o = 4'h1;
            4'h1: y_o = 4'hA;
            4'h2: y_o = 4'h4;
            4'h3: y_o = 4'hC;
            4'h4: y_o = 4'h6;
            4'h5: y_o = 4'hF;
            4'h6: y_o = 4'h3;
            4'h7: y_o = 4'h9;
            4'h8: y_o = 4'h2;
            4'h9: y_o = 4'hD;
            4'hA: y_o = 4'hB;
            4'hB: y_o = 4'h7;
            4'hC: y_o = 4'h5;
            4'hD: y_o = 4'h0;
            4'hE: y_o = 4'h8;
            default: y_o = 4'hE;
        endcase
    end

endmodule

// File: rtl/gift_subcells_sched.sv
// Sequential GIFT SubCells engine: LANES S-boxes walk the state low nibbles first.
// Optional inverse mode (inInv port) is enabled by defining GIFT_SUB_INV_EN.
module gift_subcells_sched
    import gift_subcells_sched_pkg::*;
#(
    parameter int unsigned STATE_W = 64,
    parameter int unsigned LANES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inValid,
    output logic               inReady,
    input  logic [STATE_W-1:0] inData,
    output logic               outValid,
    input  logic               outReady,
    output logic [STATE_W-1:0] outData,
    output logic               busy
`ifdef GIFT_SUB_INV_EN
    ,
    input  logic               inInv
`endif
);

    localparam int unsigned STEPS = calc_steps(STATE_W, LANES);
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    state_e             fsm_q;
    logic [CNT_W-1:0]   step_q;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               out_valid_q;
    logic               busy_q;
    logic [3:0]         lane_in  [LANES];
    logic [3:0]         lane_fwd [LANES];
    logic [3:0]         lane_out [LANES];
`ifdef GIFT_SUB_INV_EN
    logic               inv_q;
`endif

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in[l] = state_q[(32'(step_q) * LANES + l) * 4 +: 4];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        gift_subcells_sched_sbox u_sbox (
            .x_i(lane_in[g]),
            .y_o(lane_fwd[g])
        );
    end

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
`ifdef GIFT_SUB_INV_EN
            lane_out[l] = inv_q ? sbox_inv(lane_in[l]) : lane_fwd[l];
`else
            lane_out[l] = lane_fwd[l];
`endif
        end
    end

    // Only the window selected by step_q changes; other nibbles pass through.
    always_comb begin
        state_d = state_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            state_d[(32'(step_q) * LANES + l) * 4 +: 4] = lane_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            step_q      <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GIFT_SUB_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (inValid) begin
                        state_q <= inData;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        fsm_q   <= SUB;
`ifdef GIFT_SUB_INV_EN
                        inv_q   <= inInv;
`endif
                    end
                end
                SUB: begin
                    state_q <= state_d;
                    if (step_q == LAST_STEP) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (outReady) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign inReady  = (fsm_q == IDLE) && !rst;
    assign outValid = out_valid_q;
    assign busy     = busy_q;
    assign outData  = state_q;

endmodule
